// File: rtl/priority_request_capture.sv
// priority_request_capture: latches request events into a pending set and presents the
// highest-priority (lowest-numbered) pending bit through a valid/ready handshake.
module priority_request_capture #(
    parameter int NUM_REQ     = 4,
    parameter int INDEX_WIDTH = 2,
    parameter bit EDGE_MODE   = 1
) (
    input  logic                   Clock_In,
    input  logic                   Reset_In,
    input  logic                   Enable_In,
    input  logic [NUM_REQ-1:0]     Request_In,
    input  logic                   Ready_In,
    output logic                   Valid_Out,
    output logic [INDEX_WIDTH-1:0] Index_Out,
    output logic [NUM_REQ-1:0]     Pending_Out,
    output logic                   Overflow_Out
);
    typedef enum logic {IDLE, PRESENT} state_t;
    state_t state;
    logic [NUM_REQ-1:0] req_q, accept, clear;
    logic [INDEX_WIDTH-1:0] lowest;

    assign accept = (EDGE_MODE ? Request_In & ~req_q : Request_In) & {NUM_REQ{Enable_In}};
    assign clear  = (Valid_Out && Ready_In) ? NUM_REQ'(1) << Index_Out : '0;

    always_comb begin
        lowest = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--)
            if (Pending_Out[i]) lowest = INDEX_WIDTH'(i);
    end

    // set wins over clear, so a re-request on the bit being retired is kept without overflow
    always_ff @(posedge Clock_In or posedge Reset_In)
        if (Reset_In) begin
            state        <= IDLE;
            req_q        <= '0;
            Pending_Out  <= '0;
            Valid_Out    <= 1'b0;
            Index_Out    <= '0;
            Overflow_Out <= 1'b0;
        end else begin
            req_q        <= Request_In;
            Pending_Out  <= (Pending_Out & ~clear) | accept;
            Overflow_Out <= |(accept & Pending_Out & ~clear);
            if (state == IDLE && |Pending_Out) begin
                state     <= PRESENT;
                Valid_Out <= 1'b1;
                Index_Out <= lowest;
            end else if (state == PRESENT && Ready_In) begin
                state     <= IDLE;
                Valid_Out <= 1'b0;
            end
        end
endmodule

// File: tb/tb_priority_request_capture.sv
// tb_priority_request_capture: directed vector table plus random traffic checked against
// a set-based reference model, on an edge-mode and a level-mode instance.
module tb_priority_request_capture;
    logic clk = 1'b0, rst = 1'b1, en = 1'b0, rdy = 1'b0;
    logic [3:0] req = '0;
    logic ve, vl, oe, ol;
    logic [1:0] ie, il;
    logic [3:0] pe, pl;
    int errors = 0, checks = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    priority_request_capture #(.NUM_REQ(4), .INDEX_WIDTH(2), .EDGE_MODE(1)) dut_e (
        .Clock_In(clk), .Reset_In(rst), .Enable_In(en), .Request_In(req), .Ready_In(rdy),
        .Valid_Out(ve), .Index_Out(ie), .Pending_Out(pe), .Overflow_Out(oe));

    priority_request_capture #(.NUM_REQ(4), .INDEX_WIDTH(2), .EDGE_MODE(0)) dut_l (
        .Clock_In(clk), .Reset_In(rst), .Enable_In(en), .Request_In(req), .Ready_In(rdy),
        .Valid_Out(vl), .Index_Out(il), .Pending_Out(pl), .Overflow_Out(ol));

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a pending set, a "presenting" flag with its index, and the previous request word.
    typedef struct packed {
        logic [3:0] prev;
        logic [3:0] pend;
        logic       valid;
        logic [1:0] idx;
        logic       ovf;
    } model_t;
    model_t m_e, m_l;

    function automatic logic [1:0] first_set(input logic [3:0] p);
        for (int i = 0; i < 4; i++) if (p[i]) return 2'(i);
        return 2'd0;
    endfunction

    function automatic model_t nxt(input model_t s, input bit edge_m);
        model_t n = s;
        logic [3:0] ev  = edge_m ? (req & ~s.prev) : req;
        logic [3:0] acc = en ? ev : 4'b0;
        bit hs = s.valid && rdy;
        logic [3:0] clr = hs ? 4'(1 << s.idx) : 4'b0;
        n.ovf  = |(acc & s.pend & ~clr);
        n.pend = (s.pend & ~clr) | acc;
        n.prev = req;
        if (hs) n.valid = 1'b0;
        else if (!s.valid && s.pend != 0) begin
            n.valid = 1'b1;
            n.idx   = first_set(s.pend);
        end
        return n;
    endfunction

    always @(posedge clk or posedge rst)
        if (rst) begin
            m_e <= '0;
            m_l <= '0;
        end else begin
            m_e <= nxt(m_e, 1'b1);
            m_l <= nxt(m_l, 1'b0);
        end

    always @(negedge clk)
        if (chk_en && !rst) begin
            chk("edge valid", ve, m_e.valid);
            chk("edge pending", pe, m_e.pend);
            chk("edge overflow", oe, m_e.ovf);
            if (m_e.valid) chk("edge index", ie, m_e.idx);
            chk("level valid", vl, m_l.valid);
            chk("level pending", pl, m_l.pend);
            chk("level overflow", ol, m_l.ovf);
            if (m_l.valid) chk("level index", il, m_l.idx);
        end

    typedef struct {
        logic       en;
        logic [3:0] req;
        logic       rdy;
        logic       v;
        logic [1:0] idx;
        logic [3:0] pend;
        logic       ovf;
    } vec_t;
    vec_t tv[$];

    task automatic add(input logic e, input logic [3:0] r, input logic y, input logic v,
                       input logic [1:0] i, input logic [3:0] p, input logic o);
        vec_t t;
        t = '{e, r, y, v, i, p, o};
        tv.push_back(t);
    endtask

    task automatic cyc(input logic e, input logic [3:0] r, input logic y);
        @(negedge clk);
        en = e; req = r; rdy = y;
        @(posedge clk);
        #1;
    endtask

    int vcount;

    initial begin
        // single request, handshake
        add(1, 4'b0100, 0, 0, 0, 4'b0100, 0);
        add(1, 4'b0000, 1, 1, 2, 4'b0100, 0);
        add(1, 4'b0000, 1, 0, 2, 4'b0000, 0);
        // two simultaneous edges with ready tied high, bubble between
        add(1, 4'b1010, 1, 0, 2, 4'b1010, 0);
        add(1, 4'b1010, 1, 1, 1, 4'b1010, 0);
        add(1, 4'b0000, 1, 0, 1, 4'b1000, 0);
        add(1, 4'b0000, 1, 1, 3, 4'b1000, 0);
        add(1, 4'b0000, 1, 0, 3, 4'b0000, 0);
        // back-pressure holds index while a higher-priority bit arrives
        add(1, 4'b0100, 0, 0, 3, 4'b0100, 0);
        add(1, 4'b0000, 0, 1, 2, 4'b0100, 0);
        add(1, 4'b0001, 0, 1, 2, 4'b0101, 0);
        add(1, 4'b0000, 0, 1, 2, 4'b0101, 0);
        add(1, 4'b0000, 0, 1, 2, 4'b0101, 0);
        add(1, 4'b0000, 1, 0, 2, 4'b0001, 0);
        add(1, 4'b0000, 0, 1, 0, 4'b0001, 0);
        add(1, 4'b0000, 1, 0, 0, 4'b0000, 0);
        // overflow on an already-pending bit
        add(1, 4'b0010, 0, 0, 0, 4'b0010, 0);
        add(1, 4'b0000, 0, 1, 1, 4'b0010, 0);
        add(1, 4'b0010, 0, 1, 1, 4'b0010, 1);
        add(1, 4'b0000, 0, 1, 1, 4'b0010, 0);
        add(1, 4'b0000, 1, 0, 1, 4'b0000, 0);
        // set/clear collision on the presented bit
        add(1, 4'b0100, 0, 0, 1, 4'b0100, 0);
        add(1, 4'b0000, 0, 1, 2, 4'b0100, 0);
        add(1, 4'b0100, 1, 0, 2, 4'b0100, 0);
        add(1, 4'b0000, 0, 1, 2, 4'b0100, 0);
        add(1, 4'b0000, 1, 0, 2, 4'b0000, 0);
        // disabled edge ignored while pending bit drains
        add(1, 4'b0001, 0, 0, 2, 4'b0001, 0);
        add(0, 4'b0000, 0, 1, 0, 4'b0001, 0);
        add(0, 4'b1000, 0, 1, 0, 4'b0001, 0);
        add(0, 4'b0000, 1, 0, 0, 4'b0000, 0);
        add(1, 4'b0000, 0, 0, 0, 4'b0000, 0);

        #12;
        chk("reset valid", ve, 0);
        chk("reset index", ie, 0);
        chk("reset pending", pe, 0);
        chk("reset overflow", oe, 0);
        @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;

        foreach (tv[n]) begin
            cyc(tv[n].en, tv[n].req, tv[n].rdy);
            chk($sformatf("vec%0d valid", n), ve, tv[n].v);
            chk($sformatf("vec%0d index", n), ie, tv[n].idx);
            chk($sformatf("vec%0d pending", n), pe, tv[n].pend);
            chk($sformatf("vec%0d overflow", n), oe, tv[n].ovf);
        end

        // level mode captures a held line once enable rises; edge mode does not recover it
        repeat (12) cyc(1, 4'b0000, 1);
        chk("drain level pending", pl, 0);
        repeat (3) begin
            cyc(0, 4'b1000, 0);
            chk("disabled level pending", pl, 0);
            chk("disabled level overflow", ol, 0);
        end
        cyc(1, 4'b1000, 0);
        chk("reenable level pending", pl, 4'b1000);
        chk("reenable edge pending", pe, 4'b0000);
        repeat (12) cyc(1, 4'b0000, 1);

        // async reset while presenting, then a line held high through release
        cyc(1, 4'b0010, 0);
        cyc(1, 4'b0000, 0);
        chk("pre-reset valid", ve, 1);
        chk("pre-reset index", ie, 1);
        @(negedge clk);
        req = 4'b0001;
        rdy = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("async reset valid", ve, 0);
        chk("async reset pending", pe, 0);
        chk("async reset index", ie, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        vcount = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (ve) begin
                vcount++;
                chk("post-reset index", ie, 0);
            end
        end
        chk("post-reset presentations", vcount, 1);

        repeat (2000) begin
            @(negedge clk);
            en  = $urandom_range(0, 3) != 0;
            req = ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'b0;
            rdy = $urandom_range(0, 2) != 0;
        end
        @(negedge clk);
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/priority_request_capture.md
Name: priority_request_capture

Overview:
Registered request-capture stage that sits directly upstream of the 4:2 priority encoding path. It samples raw request lines, detects and latches events into a pending register, and presents the highest-priority pending request as an encoded index with a valid/ready handshake. Bit 0 has the highest priority and bit NUM_REQ-1 the lowest. Pending bits are cleared only on handshake, so no request is lost between producer and consumer.

Parameters:
NUM_REQ, 4, number of request lines (2..16).
INDEX_WIDTH, 2, width of Index_Out; must equal clog2(NUM_REQ).
EDGE_MODE, 1, 1 = capture on rising edge of Request_In; 0 = capture on level (high).

Ports:
Clock_In  input  1  single clock; all state updates on rising edge.
Reset_In  input  1  asynchronous, active-high reset.
Enable_In  input  1  1 = new request events are accepted; 0 = new events ignored.
Request_In  input  NUM_REQ  raw request lines, synchronous to Clock_In.
Ready_In  input  1  consumer accepts the presented index.
Valid_Out  output  1  Index_Out holds a valid pending request.
Index_Out  output  INDEX_WIDTH  bit number of the presented request.
Pending_Out  output  NUM_REQ  current pending register.
Overflow_Out  output  1  one-cycle pulse: an event hit a bit that was already pending.

Behaviour:
- Reset (async, immediate): req_q=0, Pending_Out=0, Valid_Out=0, Index_Out=0, Overflow_Out=0, FSM=IDLE.
- req_q registers Request_In every cycle.
- Event generation:
  - EDGE_MODE=1: event = Request_In & ~req_q.
  - EDGE_MODE=0: event = Request_In.
  - A line held high through reset release counts as one edge in the first cycle after reset.
- accept = event & {NUM_REQ{Enable_In}}.
- clear = one-hot(Index_Out) when Valid_Out && Ready_In at the edge; otherwise 0.
- Pending next = (Pending & ~clear) | accept. When set and clear hit the same bit in the same cycle, set wins: the bit stays pending and Overflow_Out is not raised.
- Overflow_Out is registered. It goes high for one cycle after an edge where accept & Pending & ~clear is nonzero. Pending_Out is unchanged by an overflow.
- FSM:
  - IDLE: Valid_Out=0. If Pending_Out is nonzero at an edge, go to PRESENT and load Index_Out = lowest set bit of Pending_Out.
  - PRESENT: Valid_Out=1. Index_Out is held stable until the handshake, even if a higher-priority bit becomes pending. On the handshake edge (Ready_In=1), clear the bit and return to IDLE.
- Latency:
  - Event sampled at edge k → Pending_Out bit set after edge k.
  - Valid_Out/Index_Out asserted after edge k+1.
  - After a handshake there is a mandatory one-cycle Valid_Out=0 bubble, so peak throughput is one index per 2 cycles.
- Enable_In=0: new events are discarded and Overflow_Out is not raised for them. Existing pending bits still drain via handshake. In EDGE_MODE=1 an edge that occurs while disabled is not recovered when Enable_In rises.
- Ready_In while Valid_Out=0 has no effect.
- Reset asserted in PRESENT: Valid_Out drops asynchronously and the request is lost. After release, only requests sampled after reset are captured.
- Index_Out never drives Z or X after reset. In IDLE it keeps its last value.

Test Plan:
1. NUM_REQ=4, after reset pulse Request_In=0100 for one cycle at edge 1 → Pending_Out=0100 after edge 1; Valid_Out=1, Index_Out=2 after edge 2; Ready_In=1 → after edge 3 Valid_Out=0, Pending_Out=0000.
2. Request_In=1010 rising together, Ready_In tied 1 → Index_Out=1 presented first. Bubble cycle with Valid_Out=0, then Index_Out=3. Pending_Out goes 1010 → 1000 → 0000.
3. Back-pressure: Valid_Out=1, Index_Out=2, Ready_In=0 for 5 cycles, and an edge on bit 0 during that time → Index_Out stays 2 and Pending_Out=0101. After the handshake, the next presented index is 0.
4. Overflow and set/clear collision:
   - Bit 1 pending, second rising edge on bit 1 without handshake → Overflow_Out=1 for exactly one cycle; Pending_Out unchanged.
   - Edge on bit 2 in the same cycle as the handshake of index 2 → bit 2 remains pending, re-presented after the bubble, Overflow_Out stays 0.
5. Enable_In=0 with an edge on bit 3 while bit 0 is pending → bit 3 never sets and Overflow_Out=0. Index 0 still presented and cleared. EDGE_MODE=0 with a level held on bit 3 and Enable_In re-raised → bit 3 captured.
6. Reset_In asserted mid-PRESENT (Index_Out=1) → Valid_Out=0, Pending_Out=0, Index_Out=0 immediately with no clock. Request_In=0001 held through release with EDGE_MODE=1 → index 0 presented exactly once and not re-captured while the level stays high.
